// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: next-PC source
// encoding and default vector addresses.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_EXC,
        SRC_BR,
        SRC_RET,
        SRC_JMP,
        SRC_SEQ,
        SRC_HOLD
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/stall inputs and fetch-address outputs of the PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              En;
    logic              ExcValid;
    logic              BrValid;
    logic [ADDR_W-1:0] BrTarget;
    logic              RetValid;
    logic [ADDR_W-1:0] RetTarget;
    logic              JmpValid;
    logic              JmpLink;
    logic [ADDR_W-1:0] JmpTarget;
    logic [ADDR_W-1:0] PCResult;
    logic [ADDR_W-1:0] PCPlus4;
    logic              RasEmpty;
    logic              RasFull;
    logic              AlignErr;

    modport master (
        output En, ExcValid, BrValid, BrTarget, RetValid, RetTarget,
               JmpValid, JmpLink, JmpTarget,
        input  PCResult, PCPlus4, RasEmpty, RasFull, AlignErr
    );

    modport slave (
        input  En, ExcValid, BrValid, BrTarget, RetValid, RetTarget,
               JmpValid, JmpLink, JmpTarget,
        output PCResult, PCPlus4, RasEmpty, RasFull, AlignErr
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is a no-op, flush drops the count but keeps the write pointer.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     wp;
    logic [CW-1:0]     cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(RAS_DEPTH));
    assign top   = mem[wp - PW'(1)];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (push) begin
            wp <= wp + PW'(1);
            if (!full) cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            wp  <= wp - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    // Entry contents need no reset; only the pointer/count define validity.
    always_ff @(posedge Clk) begin
        if (!Reset && !flush && push) mem[wp] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with fixed-priority redirect mux, stall enable,
// target word-alignment and a return-address stack for call/return.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int                RAS_DEPTH = 4
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    pc_src_e           src;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, raw_tgt, ras_top;
    logic              ras_empty, ras_full, redirect, align_q;

    assign pc_plus4     = pc_q + ADDR_W'(4);
    assign bus.PCResult = pc_q;
    assign bus.PCPlus4  = pc_plus4;
    assign bus.RasEmpty = ras_empty;
    assign bus.RasFull  = ras_full;
    assign bus.AlignErr = align_q;

    always_comb begin
        src = SRC_HOLD;
        if (Reset)             src = SRC_RESET;
        else if (bus.ExcValid) src = SRC_EXC;
        else if (bus.BrValid)  src = SRC_BR;
        else if (bus.RetValid) src = SRC_RET;
        else if (bus.JmpValid) src = SRC_JMP;
        else if (bus.En)       src = SRC_SEQ;
    end

    always_comb begin
        raw_tgt  = '0;
        redirect = 1'b0;
        pc_d     = pc_q;
        case (src)
            SRC_BR:  begin raw_tgt = bus.BrTarget;  redirect = 1'b1; end
            SRC_RET: begin raw_tgt = ras_empty ? bus.RetTarget : ras_top; redirect = 1'b1; end
            SRC_JMP: begin raw_tgt = bus.JmpTarget; redirect = 1'b1; end
            default: ;
        endcase
        case (src)
            SRC_RESET: pc_d = RESET_VEC;
            SRC_EXC:   pc_d = EXC_VEC;
            SRC_SEQ:   pc_d = pc_plus4;
            SRC_HOLD:  pc_d = pc_q;
            default:   pc_d = {raw_tgt[ADDR_W-1:2], 2'b00};
        endcase
    end

    always_ff @(posedge Clk) begin
        pc_q <= pc_d;
        if (Reset) align_q <= 1'b0;
        else       align_q <= redirect && (raw_tgt[1:0] != 2'b00);
    end

    // Stack ops follow the winning source only; a suppressed call/ret is inert.
    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     ((src == SRC_JMP) && bus.JmpLink),
        .pop      (src == SRC_RET),
        .flush    (src == SRC_EXC),
        .push_data(pc_plus4),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed check of pc_sequencer against a queue-based model.
module tb_pc_sequencer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;
    localparam logic [31:0] EVEC  = 32'h0000_0080;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_VEC(RVEC),
        .EXC_VEC  (EVEC),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_pc;
    logic        m_al;
    logic [31:0] ras_q [$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the stack is an ordered list of return addresses, newest last.
    always @(posedge Clk) begin
        logic [31:0] raw;
        bit          redir;
        redir = 1'b0;
        raw   = '0;
        if (Reset) begin
            m_pc = RVEC; ras_q.delete();
        end else if (bus.ExcValid) begin
            m_pc = EVEC; ras_q.delete();
        end else if (bus.BrValid) begin
            raw = bus.BrTarget; redir = 1'b1;
        end else if (bus.RetValid) begin
            raw = (ras_q.size() > 0) ? ras_q.pop_back() : bus.RetTarget;
            redir = 1'b1;
        end else if (bus.JmpValid) begin
            if (bus.JmpLink) begin
                ras_q.push_back(m_pc + 32'd4);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
            raw = bus.JmpTarget; redir = 1'b1;
        end else if (bus.En) begin
            m_pc = m_pc + 32'd4;
        end
        if (redir) m_pc = raw & 32'hFFFF_FFFC;
        m_al = redir && (raw % 4 != 0);
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("pc",       bus.PCResult, m_pc);
            check("pcplus4",  bus.PCPlus4,  m_pc + 32'd4);
            check("rasempty", 32'(bus.RasEmpty), 32'(ras_q.size() == 0));
            check("rasfull",  32'(bus.RasFull),  32'(ras_q.size() == DEPTH));
            check("alignerr", 32'(bus.AlignErr), 32'(m_al));
        end
    end

    task automatic clr();
        bus.En = 0; bus.ExcValid = 0; bus.BrValid = 0; bus.RetValid = 0;
        bus.JmpValid = 0; bus.JmpLink = 0;
        bus.BrTarget = '0; bus.RetTarget = '0; bus.JmpTarget = '0;
        Reset = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic call(logic [31:0] tgt);
        clr(); bus.JmpValid = 1; bus.JmpLink = 1; bus.JmpTarget = tgt; tick();
    endtask

    logic [31:0] ret_exp [5];

    initial begin
        clr();
        Reset = 1;
        tick();
        chk_en = 1'b1;
        check("rst_pc", bus.PCResult, 32'h0);
        check("rst_empty", 32'(bus.RasEmpty), 32'd1);
        check("rst_full", 32'(bus.RasFull), 32'd0);
        check("rst_align", 32'(bus.AlignErr), 32'd0);

        clr(); bus.En = 1;
        tick(); check("seq1", bus.PCResult, 32'h4);
        tick(); check("seq2", bus.PCResult, 32'h8);
        tick(); check("seq3", bus.PCResult, 32'hC);
        check("seq_empty", 32'(bus.RasEmpty), 32'd1);

        // Branch under stall, misaligned target.
        clr(); bus.BrValid = 1; bus.BrTarget = 32'h0000_0102;
        tick();
        check("br_pc", bus.PCResult, 32'h100);
        check("br_align", 32'(bus.AlignErr), 32'd1);
        clr(); tick();
        check("hold_pc", bus.PCResult, 32'h100);
        check("hold_align", 32'(bus.AlignErr), 32'd0);

        clr(); bus.BrValid = 1; bus.BrTarget = 32'h40; tick();
        call(32'h200);
        check("jal_pc", bus.PCResult, 32'h200);
        clr(); bus.RetValid = 1; tick();
        check("ret_pc", bus.PCResult, 32'h44);
        check("ret_empty", 32'(bus.RasEmpty), 32'd1);

        // Five calls into a four-deep stack, then five returns.
        ret_exp = '{32'h4004, 32'h3004, 32'h2004, 32'h1004, 32'hDEAD_BEE0};
        for (int k = 1; k <= 5; k++) begin
            call(32'h1000 * k);
            if (k == 3) check("full_after3", 32'(bus.RasFull), 32'd0);
            if (k == 4) check("full_after4", 32'(bus.RasFull), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            clr(); bus.RetValid = 1; bus.RetTarget = 32'hDEAD_BEE0; tick();
            check($sformatf("ret%0d", k), bus.PCResult, ret_exp[k]);
        end

        call(32'h300);
        call(32'h400);
        clr(); bus.ExcValid = 1; bus.BrValid = 1; bus.BrTarget = 32'h500;
        bus.RetValid = 1; tick();
        check("exc_pc", bus.PCResult, 32'h80);
        check("exc_empty", 32'(bus.RasEmpty), 32'd1);
        clr(); bus.RetValid = 1; bus.RetTarget = 32'h600; tick();
        check("post_exc_ret", bus.PCResult, 32'h600);

        clr(); bus.BrValid = 1; bus.BrTarget = 32'hFFFF_FFFC; tick();
        check("pc_top", bus.PCResult, 32'hFFFF_FFFC);
        check("plus4_wrap", bus.PCPlus4, 32'h0);
        clr(); bus.En = 1; tick();
        check("wrap_pc", bus.PCResult, 32'h0);
        call(32'h700);
        clr(); Reset = 1; bus.JmpValid = 1; bus.JmpLink = 1; bus.JmpTarget = 32'h300; tick();
        check("rst_jmp_pc", bus.PCResult, RVEC);
        check("rst_jmp_empty", 32'(bus.RasEmpty), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            clr();
            Reset         = ($urandom_range(0, 99) < 2);
            bus.En        = ($urandom_range(0, 99) < 70);
            bus.ExcValid  = ($urandom_range(0, 99) < 4);
            bus.BrValid   = ($urandom_range(0, 99) < 12);
            bus.RetValid  = ($urandom_range(0, 99) < 20);
            bus.JmpValid  = ($urandom_range(0, 99) < 25);
            bus.JmpLink   = ($urandom_range(0, 99) < 70);
            bus.BrTarget  = $urandom();
            bus.RetTarget = $urandom();
            bus.JmpTarget = $urandom();
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
